// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - round-robin burst arbiter sharing the async FIFO write port
// Optional packet lock (hold grant until req_last): define FIFO_ARB_PKT_LOCK_EN.
module fifo_wr_arb #(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 4,
    parameter int BURST_MAX = 4
) (
    input  logic                         wr_clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NUM_REQ*WIDTH-1:0]     req_data_i,
    input  logic [NUM_REQ-1:0]           req_last_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic                         fifo_full_i,
    output logic                         fifo_wr_en_o,
    output logic [WIDTH-1:0]             fifo_wdata_o,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id_o,
    output logic                         busy_o
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX - 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] last_owner_q, last_owner_d;
    logic [CW-1:0]  beat_cnt_q, beat_cnt_d;
    logic [IDW-1:0] pick_id;
    logic [WIDTH-1:0] owner_data;
    logic           beat;

    assign owner_data = req_data_i[int'(owner_q)*WIDTH +: WIDTH];
    assign grant_id_o = owner_q;
    assign busy_o     = (state_q == XFER);

    // Descending scan so the candidate closest after last_owner_q wins.
    always_comb begin
        pick_id = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_valid_i[(int'(last_owner_q) + k) % NUM_REQ]) begin
                pick_id = IDW'((int'(last_owner_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        req_ready_o  = '0;
        fifo_wr_en_o = 1'b0;
        fifo_wdata_o = '0;
        beat         = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid_i) begin
                    state_d    = XFER;
                    owner_d    = pick_id;
                    beat_cnt_d = '0;
                end
            end
            XFER: begin
                req_ready_o[owner_q] = !fifo_full_i;
                beat                 = req_valid_i[owner_q] && !fifo_full_i;
                fifo_wr_en_o         = beat;
                if (beat) fifo_wdata_o = owner_data;
`ifdef FIFO_ARB_PKT_LOCK_EN
                if (beat) begin
                    if (req_last_i[owner_q]) begin
                        state_d      = IDLE;
                        last_owner_d = owner_q;
                    end else if (beat_cnt_q != CNT_MAX) begin
                        beat_cnt_d = beat_cnt_q + CW'(1);
                    end
                end
`else
                // A dropped valid releases even when full, so it is tested first.
                if (!req_valid_i[owner_q]) begin
                    state_d      = IDLE;
                    last_owner_d = owner_q;
                end else if (beat) begin
                    if (req_last_i[owner_q] || beat_cnt_q == CNT_MAX) begin
                        state_d      = IDLE;
                        last_owner_d = owner_q;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CW'(1);
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= IDW'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb/tb_fifo_wr_arb.sv - directed and randomized self-checking bench for fifo_wr_arb
module tb_fifo_wr_arb;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int BM = 4;
    localparam int IW = 2;
`ifdef FIFO_ARB_PKT_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic           wr_clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic           fifo_full = 1'b0;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_wdata;
    logic [IW-1:0]  grant_id;
    logic           busy;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 wr_clk = ~wr_clk;

    fifo_wr_arb #(.WIDTH(W), .NUM_REQ(N), .BURST_MAX(BM)) dut (
        .wr_clk(wr_clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
        .req_ready_o(req_ready), .fifo_full_i(fifo_full),
        .fifo_wr_en_o(fifo_wr_en), .fifo_wdata_o(fifo_wdata),
        .grant_id_o(grant_id), .busy_o(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [W-1:0] d);
        req_data[i*W +: W] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        fifo_full = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    // Round-robin rule: first valid requester after the previous owner.
    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    logic [W-1:0] got[$];
    logic [W-1:0] w[N];
    bit           l[N];

    initial begin
        int writes, idx, stall_left, p, m_owner, m_last, m_beats;
        bit stalled, m_busy, exp_we;

        // Reset held with every requester valid
        rst_n = 1'b0;
        req_valid = '1;
        req_data = {N{8'h5A}};
        cyc();
        cyc();
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_wr_en", 32'(fifo_wr_en), 32'h0);
        check("rst_wdata", 32'(fifo_wdata), 32'h0);
        check("rst_grant", 32'(grant_id), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        cyc();
        check("rst_rel_busy", 32'(busy), 32'h1);
        check("rst_rel_grant", 32'(grant_id), 32'h0);

        // Single packet from requester 1
        do_reset();
        req_valid = 4'b0010;
        set_data(1, 8'h11);
        cyc();
        check("pkt_busy", 32'(busy), 32'h1);
        check("pkt_grant", 32'(grant_id), 32'h1);
        check("pkt_ready", 32'(req_ready), 32'h2);
        check("pkt_we0", 32'(fifo_wr_en), 32'h1);
        check("pkt_d0", 32'(fifo_wdata), 32'h11);
        cyc();
        set_data(1, 8'h22);
        #1;
        check("pkt_we1", 32'(fifo_wr_en), 32'h1);
        check("pkt_d1", 32'(fifo_wdata), 32'h22);
        cyc();
        set_data(1, 8'h33);
        req_last = 4'b0010;
        #1;
        check("pkt_we2", 32'(fifo_wr_en), 32'h1);
        check("pkt_d2", 32'(fifo_wdata), 32'h33);
        cyc();
        req_valid = '0;
        req_last = '0;
        #1;
        check("pkt_end_busy", 32'(busy), 32'h0);
        check("pkt_end_we", 32'(fifo_wr_en), 32'h0);

        // Fairness: all valid, no last -> 4-beat bursts, one idle cycle between
        do_reset();
        req_valid = '1;
        for (int i = 0; i < N; i++) set_data(i, W'(8'hA0 + i));
        writes = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            check("fair_we", 32'(fifo_wr_en), 32'((c % 5) != 4));
            if ((c % 5) != 4) begin
                check("fair_grant", 32'(grant_id), 32'(c / 5));
                check("fair_data", 32'(fifo_wdata), 32'(8'hA0 + c / 5));
            end
            writes += int'(fifo_wr_en);
        end
        check("fair_total", 32'(writes), 32'd16);
        cyc();
        check("fair_wrap_grant", 32'(grant_id), 32'h0);
        check("fair_wrap_busy", 32'(busy), 32'h1);

        // Full stall for 3 cycles after the second beat
        do_reset();
        idx = 0;
        stall_left = 0;
        stalled = 1'b0;
        got.delete();
        for (int c = 0; c < 12; c++) begin
            req_valid = (idx < 4) ? 4'b0100 : 4'b0000;
            set_data(2, W'(8'h40 + idx));
            req_last = (idx == 3) ? 4'b0100 : 4'b0000;
            fifo_full = (stall_left > 0);
            #1;
            if (fifo_full) begin
                check("stall_we", 32'(fifo_wr_en), 32'h0);
                check("stall_ready", 32'(req_ready), 32'h0);
                stall_left--;
            end
            if (fifo_wr_en) begin
                got.push_back(fifo_wdata);
                idx++;
                if (idx == 2 && !stalled) begin
                    stall_left = 3;
                    stalled = 1'b1;
                end
            end
            cyc();
        end
        fifo_full = 1'b0;
        check("stall_count", 32'(got.size()), 32'd4);
        for (int k = 0; k < got.size(); k++) check("stall_data", 32'(got[k]), 32'(8'h40 + k));
        check("stall_end_busy", 32'(busy), 32'h0);

        // Owner 0 drops valid after one beat while requester 2 waits
        do_reset();
        req_valid = 4'b0101;
        set_data(0, 8'h50);
        set_data(2, 8'h70);
        req_last = 4'b0100;
        cyc();
        check("drop_grant0", 32'(grant_id), 32'h0);
        check("drop_we0", 32'(fifo_wr_en), 32'h1);
        check("drop_d0", 32'(fifo_wdata), 32'h50);
        cyc();
        req_valid = 4'b0100;
        #1;
        check("drop_no_we", 32'(fifo_wr_en), 32'h0);
        cyc();
`ifdef FIFO_ARB_PKT_LOCK_EN
        check("lock_held_busy", 32'(busy), 32'h1);
        check("lock_held_grant", 32'(grant_id), 32'h0);
        req_valid = 4'b0101;
        set_data(0, 8'h51);
        req_last = 4'b0101;
        #1;
        check("lock_resume_we", 32'(fifo_wr_en), 32'h1);
        check("lock_resume_d", 32'(fifo_wdata), 32'h51);
        cyc();
        req_valid = 4'b0100;
        #1;
        check("lock_idle", 32'(busy), 32'h0);
        cyc();
`else
        check("drop_idle", 32'(busy), 32'h0);
        cyc();
`endif
        check("drop_grant2", 32'(grant_id), 32'h2);
        check("drop_we2", 32'(fifo_wr_en), 32'h1);
        check("drop_d2", 32'(fifo_wdata), 32'h70);
        cyc();
        req_valid = '0;
        req_last = '0;

        // Asynchronous reset pulse during beat 2
        do_reset();
        req_valid = 4'b0011;
        set_data(0, 8'h60);
        set_data(1, 8'h61);
        cyc();
        check("arst_beat1", 32'(fifo_wr_en), 32'h1);
        cyc();
        check("arst_beat2", 32'(fifo_wr_en), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_we", 32'(fifo_wr_en), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_ready", 32'(req_ready), 32'h0);
        #1;
        rst_n = 1'b1;
        cyc();
        check("arst_regrant_busy", 32'(busy), 32'h1);
        check("arst_regrant_id", 32'(grant_id), 32'h0);

        // Randomized traffic against a transaction-level reference
        do_reset();
        m_busy = 1'b0;
        m_owner = 0;
        m_last = N - 1;
        m_beats = 0;
        for (int i = 0; i < N; i++) begin
            w[i] = W'($urandom);
            l[i] = ($urandom_range(0, 99) < 30);
        end
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                req_valid[i] = ($urandom_range(0, 99) < 85);
                set_data(i, w[i]);
                req_last[i] = l[i];
            end
            fifo_full = ($urandom_range(0, 99) < 20);
            #1;
            exp_we = m_busy && !fifo_full && req_valid[m_owner];
            check("rnd_busy", 32'(busy), 32'(m_busy));
            check("rnd_ready", 32'(req_ready), (m_busy && !fifo_full) ? 32'(1 << m_owner) : 32'h0);
            check("rnd_we", 32'(fifo_wr_en), 32'(exp_we));
            check("rnd_wdata", 32'(fifo_wdata), exp_we ? 32'(w[m_owner]) : 32'h0);
            if (m_busy) check("rnd_grant", 32'(grant_id), 32'(m_owner));
            if (!m_busy) begin
                p = rr_pick(m_last, req_valid);
                if (p >= 0) begin
                    m_busy = 1'b1;
                    m_owner = p;
                    m_beats = 0;
                end
            end else if (exp_we) begin
                m_beats++;
                if (l[m_owner] || (!LOCK && m_beats == BM)) begin
                    m_busy = 1'b0;
                    m_last = m_owner;
                end
                w[m_owner] = W'($urandom);
                l[m_owner] = ($urandom_range(0, 99) < 30);
            end else if (!LOCK && !req_valid[m_owner]) begin
                m_busy = 1'b0;
                m_last = m_owner;
            end
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
